// File: rtl/phy_rx_deser_align.sv
// Multi-lane serial-to-parallel receiver with per-lane comma byte alignment.
// Each lane shifts in one bit per clk_32f cycle (MSB first), hunts for the
// comma pattern at any bit phase, confirms it on consecutive byte boundaries
// and then emits data bytes with valid/strobe qualifiers. Lanes are fully
// independent and may lock on different bit phases.
module phy_rx_deser_align #(
    parameter int unsigned LANES       = 2,
    parameter logic [7:0]  COMMA       = 8'hBC,
    parameter int unsigned ALIGN_COUNT = 4,
    parameter int unsigned LOSS_COUNT  = 0
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    input  logic [LANES-1:0]     ser_in,
    output logic [8*LANES-1:0]   data_out,
    output logic [LANES-1:0]     valid_out,
    output logic [LANES-1:0]     byte_strobe,
    output logic [LANES-1:0]     active
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCK    = 2'd1,
        ALIGNED = 2'd2
    } state_t;

    localparam logic [3:0] ALIGN_TGT = 4'(ALIGN_COUNT);
    localparam logic [7:0] LOSS_TGT  = 8'(LOSS_COUNT);
    localparam logic       LOSS_EN   = (LOSS_COUNT != 0);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Seven previous bits; together with the live input bit they form
        // the byte window ending at the current bit.
        logic [6:0] sh;
        state_t     state;
        logic [2:0] bit_cnt;
        logic [3:0] comma_cnt;
        logic [7:0] loss_cnt;
        logic [7:0] data_q;
        logic       valid_q;
        logic       strobe_q;
        logic       active_q;

        logic [7:0] win;
        logic       is_comma;
        logic       boundary;
        logic [3:0] comma_nxt;
        logic [7:0] loss_nxt;

        // Byte window, boundary detect and saturating counter increments
        always_comb begin
            win       = {sh, ser_in[i]};
            is_comma  = (win == COMMA);
            boundary  = (bit_cnt == 3'd7);
            comma_nxt = (comma_cnt >= ALIGN_TGT) ? ALIGN_TGT : comma_cnt + 4'd1;
            loss_nxt  = (loss_cnt == 8'hFF) ? 8'hFF : loss_cnt + 8'd1;
        end

        // Per-lane shift register, alignment FSM and registered outputs
        always_ff @(posedge clk_32f) begin
            if (reset) begin
                sh        <= '0;
                state     <= HUNT;
                bit_cnt   <= '0;
                comma_cnt <= '0;
                loss_cnt  <= '0;
                data_q    <= '0;
                valid_q   <= 1'b0;
                strobe_q  <= 1'b0;
                active_q  <= 1'b0;
            end else begin
                sh       <= win[6:0];
                strobe_q <= 1'b0;
                case (state)
                    HUNT: begin
                        valid_q  <= 1'b0;
                        active_q <= 1'b0;
                        loss_cnt <= '0;
                        if (is_comma) begin
                            // This bit becomes the byte end for all later boundaries
                            bit_cnt <= '0;
                            if (ALIGN_TGT == 4'd1) begin
                                state     <= ALIGNED;
                                active_q  <= 1'b1;
                                comma_cnt <= ALIGN_TGT;
                            end else begin
                                state     <= LOCK;
                                comma_cnt <= 4'd1;
                            end
                        end
                    end

                    LOCK: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (boundary) begin
                            if (is_comma) begin
                                comma_cnt <= comma_nxt;
                                if (comma_nxt >= ALIGN_TGT) begin
                                    state    <= ALIGNED;
                                    active_q <= 1'b1;
                                    loss_cnt <= '0;
                                end
                            end else begin
                                // Broken comma run: resume hunting from the next bit
                                state     <= HUNT;
                                comma_cnt <= '0;
                            end
                        end
                    end

                    ALIGNED: begin
                        active_q <= 1'b1;
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (boundary) begin
                            strobe_q <= 1'b1;
                            if (is_comma) begin
                                valid_q  <= 1'b0;
                                loss_cnt <= '0;
                            end else begin
                                data_q   <= win;
                                valid_q  <= 1'b1;
                                loss_cnt <= loss_nxt;
                                // Last data byte is still presented; active and
                                // valid are cleared by HUNT on the following edge.
                                if (LOSS_EN && (loss_nxt >= LOSS_TGT)) begin
                                    state <= HUNT;
                                end
                            end
                        end
                    end

                    default: begin
                        state <= HUNT;
                    end
                endcase
            end
        end

        // Drive this lane's slice of the output buses
        assign data_out[8*i +: 8] = data_q;
        assign valid_out[i]       = valid_q;
        assign byte_strobe[i]     = strobe_q;
        assign active[i]          = active_q;
    end

endmodule

// File: tb/tb_phy_rx_deser_align.sv
// Testbench for phy_rx_deser_align: three instances with different
// parameter sets, a byte-level reference model checked every cycle,
// a table of directed byte sequences and a few multi-cycle sequences.
module tb_phy_rx_deser_align;

    logic        clk_32f = 1'b0;
    logic        reset;
    logic [1:0]  ser  [3];
    logic [15:0] dout [3];
    logic [1:0]  vout [3];
    logic [1:0]  sout [3];
    logic [1:0]  aout [3];

    always #5 clk_32f = ~clk_32f;

    phy_rx_deser_align #(.LANES(2), .COMMA(8'hBC), .ALIGN_COUNT(4), .LOSS_COUNT(0)) dut_a (
        .clk_32f(clk_32f), .reset(reset), .ser_in(ser[0]),
        .data_out(dout[0]), .valid_out(vout[0]), .byte_strobe(sout[0]), .active(aout[0]));

    phy_rx_deser_align #(.LANES(2), .COMMA(8'hBC), .ALIGN_COUNT(4), .LOSS_COUNT(4)) dut_b (
        .clk_32f(clk_32f), .reset(reset), .ser_in(ser[1]),
        .data_out(dout[1]), .valid_out(vout[1]), .byte_strobe(sout[1]), .active(aout[1]));

    phy_rx_deser_align #(.LANES(2), .COMMA(8'hC5), .ALIGN_COUNT(1), .LOSS_COUNT(2)) dut_c (
        .clk_32f(clk_32f), .reset(reset), .ser_in(ser[2]),
        .data_out(dout[2]), .valid_out(vout[2]), .byte_strobe(sout[2]), .active(aout[2]));

    // Parameters of each instance, as seen by the model
    int p_align [3] = '{4, 4, 1};
    int p_loss  [3] = '{0, 4, 2};
    int p_comma [3] = '{32'hBC, 32'hBC, 32'hC5};

    // Reference model: last 8 received bits, mode (0 hunt, 1 lock, 2 aligned),
    // bits received since the last byte end, and expected outputs.
    int         m_hist   [3][2];
    int         m_mode   [3][2];
    int         m_pos    [3][2];
    int         m_commas [3][2];
    int         m_losses [3][2];
    logic [7:0] m_data   [3][2];
    logic       m_valid  [3][2];
    logic       m_strobe [3][2];
    logic       m_active [3][2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    function automatic void model_step(input int n, input int l, input logic b, input logic r);
        int w;
        if (r) begin
            m_hist[n][l] = 0; m_mode[n][l] = 0; m_pos[n][l] = 0;
            m_commas[n][l] = 0; m_losses[n][l] = 0;
            m_data[n][l] = 8'h00; m_valid[n][l] = 1'b0;
            m_strobe[n][l] = 1'b0; m_active[n][l] = 1'b0;
            return;
        end
        w = ((m_hist[n][l] << 1) | int'(b)) & 255;
        m_hist[n][l] = w;
        m_strobe[n][l] = 1'b0;
        if (m_mode[n][l] == 0) begin
            m_valid[n][l]  = 1'b0;
            m_active[n][l] = 1'b0;
            if (w == p_comma[n]) begin
                m_pos[n][l]    = 0;
                m_commas[n][l] = 1;
                m_losses[n][l] = 0;
                if (p_align[n] == 1) begin
                    m_mode[n][l]   = 2;
                    m_active[n][l] = 1'b1;
                end else begin
                    m_mode[n][l] = 1;
                end
            end
        end else begin
            m_pos[n][l] = m_pos[n][l] + 1;
            if (m_pos[n][l] == 8) begin
                m_pos[n][l] = 0;
                if (m_mode[n][l] == 1) begin
                    if (w == p_comma[n]) begin
                        m_commas[n][l] = m_commas[n][l] + 1;
                        if (m_commas[n][l] >= p_align[n]) begin
                            m_mode[n][l]   = 2;
                            m_active[n][l] = 1'b1;
                            m_losses[n][l] = 0;
                        end
                    end else begin
                        m_mode[n][l]   = 0;
                        m_commas[n][l] = 0;
                    end
                end else begin
                    m_strobe[n][l] = 1'b1;
                    if (w == p_comma[n]) begin
                        m_valid[n][l]  = 1'b0;
                        m_losses[n][l] = 0;
                    end else begin
                        m_data[n][l]  = w[7:0];
                        m_valid[n][l] = 1'b1;
                        if (m_losses[n][l] < 255) m_losses[n][l] = m_losses[n][l] + 1;
                        if (p_loss[n] != 0 && m_losses[n][l] >= p_loss[n]) m_mode[n][l] = 0;
                    end
                end
            end
        end
    endfunction

    function automatic logic [21:0] model_pack(input int n);
        return {m_data[n][1], m_data[n][0], m_valid[n][1], m_valid[n][0],
                m_strobe[n][1], m_strobe[n][0], m_active[n][1], m_active[n][0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One bit period: drive, clock, advance the model, compare every output
    task automatic tick(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic r);
        logic [1:0] sv [3];
        sv[0] = a; sv[1] = b; sv[2] = c;
        ser[0] = a; ser[1] = b; ser[2] = c; reset = r;
        @(posedge clk_32f);
        cyc++;
        for (int n = 0; n < 3; n++)
            for (int l = 0; l < 2; l++)
                model_step(n, l, sv[n][l], r);
        #1;
        for (int n = 0; n < 3; n++)
            check($sformatf("cycle_dut%0d", n),
                  {10'b0, dout[n], vout[n], sout[n], aout[n]}, {10'b0, model_pack(n)});
    endtask

    task automatic send_bit(input logic [2:0] mask, input int lane, input logic b);
        logic [1:0] v;
        v = 2'b00;
        v[lane] = b;
        tick(mask[0] ? v : 2'b00, mask[1] ? v : 2'b00, mask[2] ? v : 2'b00, 1'b0);
    endtask

    task automatic send_byte(input logic [2:0] mask, input int lane, input logic [7:0] v);
        for (int k = 7; k >= 0; k--) send_bit(mask, lane, v[k]);
    endtask

    task automatic do_reset();
        tick(2'b00, 2'b00, 2'b00, 1'b1);
    endtask

    typedef struct {
        int          lane;
        int          njunk;
        logic [15:0] junk;
        int          nb;
        logic [79:0] seq;
        logic        exp_active;
        logic [7:0]  exp_data;
        logic        exp_valid;
        logic        exp_strobe;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int vcnt;
        int scnt;
        logic [7:0] g_cur [3][2];
        int         g_n   [3][2];

        tbl[0] = '{0, 16, 16'h0000, 5, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hA5, 40'h0}, 1'b1, 8'hA5, 1'b1, 1'b1};
        tbl[1] = '{1, 3, 16'h0005, 5, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h3C, 40'h0}, 1'b1, 8'h3C, 1'b1, 1'b1};
        tbl[2] = '{0, 0, 16'h0000, 4, {8'hBC, 8'hBC, 8'hBC, 8'h55, 48'h0}, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{0, 0, 16'h0000, 9, {8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h0F, 8'h0},
                   1'b1, 8'h0F, 1'b1, 1'b1};
        tbl[4] = '{0, 0, 16'h0000, 6, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h77, 8'hBC, 32'h0}, 1'b1, 8'h77, 1'b0, 1'b1};
        tbl[5] = '{1, 0, 16'h0000, 4, {8'hBC, 8'hBC, 8'hBC, 8'hBC, 48'h0}, 1'b1, 8'h00, 1'b0, 1'b0};

        ser[0] = 2'b00; ser[1] = 2'b00; ser[2] = 2'b00; reset = 1'b1;
        do_reset();
        check("reset_outputs", {10'b0, dout[0], vout[0], sout[0], aout[0]}, 32'h0);

        // Directed byte sequences on dut_a
        for (int r = 0; r < 6; r++) begin
            logic [79:0] s;
            int ln;
            ln = tbl[r].lane;
            do_reset();
            for (int k = tbl[r].njunk - 1; k >= 0; k--) send_bit(3'b001, ln, tbl[r].junk[k]);
            s = tbl[r].seq;
            for (int k = 0; k < tbl[r].nb; k++) begin
                send_byte(3'b001, ln, s[79:72]);
                s = s << 8;
            end
            check($sformatf("rec%0d_active", r), 32'(aout[0][ln]), 32'(tbl[r].exp_active));
            check($sformatf("rec%0d_data", r), 32'(dout[0][8*ln +: 8]), 32'(tbl[r].exp_data));
            check($sformatf("rec%0d_valid", r), 32'(vout[0][ln]), 32'(tbl[r].exp_valid));
            check($sformatf("rec%0d_strobe", r), 32'(sout[0][ln]), 32'(tbl[r].exp_strobe));
            check($sformatf("rec%0d_other_idle", r), 32'(aout[0][1-ln]), 32'd0);
        end

        // Valid holds for one byte period; strobe on every aligned boundary
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(3'b001, 0, 8'hBC);
        check("hold_locked", 32'(aout[0][0]), 32'd1);
        vcnt = 0; scnt = 0;
        for (int b = 0; b < 3; b++) begin
            logic [7:0] v;
            v = (b == 1) ? 8'h12 : 8'hBC;
            for (int k = 7; k >= 0; k--) begin
                send_bit(3'b001, 0, v[k]);
                vcnt += int'(vout[0][0]);
                scnt += int'(sout[0][0]);
            end
        end
        check("hold_valid_cycles", 32'(vcnt), 32'd8);
        check("hold_strobes", 32'(scnt), 32'd3);
        check("hold_data_kept", 32'(dout[0][7:0]), 32'h12);
        check("hold_valid_off", 32'(vout[0][0]), 32'd0);

        // Reset in the middle of a data byte
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(3'b001, 0, 8'hBC);
        send_byte(3'b001, 0, 8'h77);
        for (int k = 0; k < 4; k++) send_bit(3'b001, 0, 1'b1);
        check("midrst_no_partial", 32'(dout[0][7:0]), 32'h77);
        tick(2'b00, 2'b00, 2'b00, 1'b1);
        check("midrst_cleared", {25'b0, dout[0][7:0], vout[0][0], sout[0][0], aout[0][0]}, 32'h0);
        for (int k = 0; k < 3; k++) send_bit(3'b001, 0, 1'b0);
        for (int k = 0; k < 3; k++) send_byte(3'b001, 0, 8'hBC);
        check("midrst_need_fresh", 32'(aout[0][0]), 32'd0);
        send_byte(3'b001, 0, 8'hBC);
        check("midrst_relock", 32'(aout[0][0]), 32'd1);
        send_byte(3'b001, 0, 8'h5A);
        check("midrst_data", {23'b0, dout[0][7:0], vout[0][0]}, {23'b0, 8'h5A, 1'b1});

        // Loss of lock after four data bytes (dut_b) vs. disabled detection (dut_a)
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(3'b011, 0, 8'hBC);
        for (int v = 1; v <= 4; v++) begin
            send_byte(3'b011, 0, 8'(v));
            check($sformatf("loss_byte%0d", v), {22'b0, dout[1][7:0], vout[1][0], aout[1][0]},
                  {22'b0, 8'(v), 1'b1, 1'b1});
        end
        send_bit(3'b011, 0, 1'b0);
        check("loss_dropped", {22'b0, dout[1][7:0], vout[1][0], aout[1][0]}, {22'b0, 8'h04, 2'b00});
        check("noloss_kept", {30'b0, vout[0][0], aout[0][0]}, 32'h3);
        for (int k = 0; k < 15; k++) send_bit(3'b011, 0, 1'b0);
        check("loss_stays_hunt", 32'(aout[1][0]), 32'd0);

        // Randomised streams on all lanes, checked by the model each cycle
        do_reset();
        for (int n = 0; n < 3; n++)
            for (int l = 0; l < 2; l++) g_n[n][l] = 0;
        for (int t = 0; t < 4000; t++) begin
            logic [1:0] v [3];
            for (int n = 0; n < 3; n++) begin
                v[n] = 2'b00;
                for (int l = 0; l < 2; l++) begin
                    if (g_n[n][l] == 0) begin
                        int r;
                        r = int'($urandom_range(0, 99));
                        if (r < 60) begin
                            g_cur[n][l] = 8'(p_comma[n]); g_n[n][l] = 8;
                        end else if (r < 68) begin
                            g_cur[n][l] = 8'($urandom); g_n[n][l] = int'($urandom_range(1, 7));
                        end else begin
                            g_cur[n][l] = 8'($urandom); g_n[n][l] = 8;
                        end
                    end
                    v[n][l] = g_cur[n][l][g_n[n][l] - 1];
                    g_n[n][l] = g_n[n][l] - 1;
                end
            end
            tick(v[0], v[1], v[2], ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
